// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential Booth multiplier.
// Configuration macro: MULT_MULTU_EN (adds unsigned operation, one extra Booth step).
// Contents: FSM state enum, step-count helpers, counter width, Booth recode constants.
package mult_pkg;

    typedef enum logic [0:0] {
        MULT_IDLE,
        MULT_RUN
    } mult_state_e;

    localparam int unsigned MULT_WIDTH = 32;

    // Number of Booth steps for a given operand width.
    function automatic int unsigned mult_steps(input int unsigned width);
`ifdef MULT_MULTU_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Width of the multiplier (q) field: one extra bit when unsigned operands are supported.
    function automatic int unsigned mult_qw(input int unsigned width);
`ifdef MULT_MULTU_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    localparam int unsigned MULT_STEPS = mult_steps(MULT_WIDTH);
    localparam int unsigned MULT_CNT_W = $clog2(MULT_STEPS);

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/mult_seq_booth_step.sv
// booth_step: one combinational radix-2 Booth step.
// Ports:
//   i_acc, i_q, i_q_m1 : current product register fields {acc, q, q_m1}
//   i_m                : multiplicand, already extended to AW bits
//   o_acc, o_q, o_q_m1 : product register after add/sub and arithmetic shift right by 1
module booth_step
    import mult_pkg::*;
#(
    parameter int unsigned AW = 33,
    parameter int unsigned QW = 32
) (
    input  logic [AW-1:0] i_acc,
    input  logic [QW-1:0] i_q,
    input  logic          i_q_m1,
    input  logic [AW-1:0] i_m,
    output logic [AW-1:0] o_acc,
    output logic [QW-1:0] o_q,
    output logic          o_q_m1
);

    logic [AW-1:0] w_sum;

    always_comb begin
        case ({i_q[0], i_q_m1})
            BOOTH_ADD: w_sum = i_acc + i_m;
            BOOTH_SUB: w_sum = i_acc - i_m;
            default:   w_sum = i_acc;
        endcase
        // Arithmetic shift of the concatenation {acc, q, q_m1}.
        o_acc  = {w_sum[AW-1], w_sum[AW-1:1]};
        o_q    = {w_sum[0], i_q[QW-1:1]};
        o_q_m1 = i_q[0];
    end

endmodule

// File: rtl/mult_seq.sv
// mult_seq: sequential radix-2 Booth multiplier, one step per clock, result into Hi/Lo.
// Configuration macro: MULT_MULTU_EN (adds unsigned_op; operands get one extra bit and
// the operation takes WIDTH+1 steps for both signed and unsigned).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   start, A, B       : request and operands, sampled only in IDLE
//   unsigned_op       : (MULT_MULTU_EN only) 1 = multu, 0 = mult
//   busy, done        : operation in flight / one-cycle completion pulse
//   Hi, Lo            : last completed product, upper and lower words
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef MULT_MULTU_EN
    input  logic             unsigned_op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int unsigned STEPS = mult_steps(WIDTH);
    localparam int unsigned QW    = mult_qw(WIDTH);
    // Accumulator carries one bit more than q so the most negative multiplicand cannot overflow.
    localparam int unsigned AW    = QW + 1;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    mult_state_e   r_state, w_state_next;
    logic [AW-1:0] r_acc, w_acc_next;
    logic [QW-1:0] r_q, w_q_next;
    logic          r_q_m1, w_q_m1_next;
    logic [AW-1:0] r_m, w_m_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic          r_busy, w_busy_next;
    logic          r_done, w_done_next;
    logic [WIDTH-1:0] r_hi, w_hi_next;
    logic [WIDTH-1:0] r_lo, w_lo_next;

    logic [AW-1:0]      w_step_acc;
    logic [QW-1:0]      w_step_q;
    logic               w_step_q_m1;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_a_ext;
    logic [AW-1:0]      w_m_ext;
    logic [QW-1:0]      w_q_ext;

`ifdef MULT_MULTU_EN
    assign w_a_ext = unsigned_op ? 1'b0 : A[WIDTH-1];
    assign w_q_ext = {(unsigned_op ? 1'b0 : B[WIDTH-1]), B};
`else
    assign w_a_ext = A[WIDTH-1];
    assign w_q_ext = B;
`endif
    assign w_m_ext = {{(AW-WIDTH){w_a_ext}}, A};

    booth_step #(
        .AW (AW),
        .QW (QW)
    ) u_booth_step (
        .i_acc  (r_acc),
        .i_q    (r_q),
        .i_q_m1 (r_q_m1),
        .i_m    (r_m),
        .o_acc  (w_step_acc),
        .o_q    (w_step_q),
        .o_q_m1 (w_step_q_m1)
    );

    // Product is the low 2*WIDTH bits of {acc, q} after the final step.
    assign w_prod = {w_step_acc[2*WIDTH-QW-1:0], w_step_q};

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_q_next     = r_q;
        w_q_m1_next  = r_q_m1;
        w_m_next     = r_m;
        w_cnt_next   = r_cnt;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;
        case (r_state)
            MULT_IDLE: begin
                if (start) begin
                    w_state_next = MULT_RUN;
                    w_acc_next   = '0;
                    w_q_next     = w_q_ext;
                    w_q_m1_next  = 1'b0;
                    w_m_next     = w_m_ext;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b1;
                end
            end
            MULT_RUN: begin
                w_acc_next  = w_step_acc;
                w_q_next    = w_step_q;
                w_q_m1_next = w_step_q_m1;
                w_cnt_next  = r_cnt + CW'(1);
                if (r_cnt == CW'(STEPS - 1)) begin
                    w_state_next = MULT_IDLE;
                    w_cnt_next   = '0;
                    w_busy_next  = 1'b0;
                    w_done_next  = 1'b1;
                    w_hi_next    = w_prod[2*WIDTH-1:WIDTH];
                    w_lo_next    = w_prod[WIDTH-1:0];
                end
            end
            default: begin
                w_state_next = MULT_IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= MULT_IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_q_m1  <= 1'b0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_q     <= w_q_next;
            r_q_m1  <= w_q_m1_next;
            r_m     <= w_m_next;
            r_cnt   <= w_cnt_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: self-checking bench for mult_seq with a plain-arithmetic product model.
// Configuration macro: MULT_MULTU_EN (exercises unsigned_op and 33-cycle latency).
module tb_mult_seq;

    localparam int W = 32;
`ifdef MULT_MULTU_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         uop = 1'b0;
    logic         busy, done;
    logic [W-1:0] Hi, Lo;

    int total = 0;
    int bad = 0;
    logic [63:0] last_res = '0;

    mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .A           (A),
        .B           (B),
`ifdef MULT_MULTU_EN
        .unsigned_op (uop),
`endif
        .busy        (busy),
        .done        (done),
        .Hi          (Hi),
        .Lo          (Lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic u);
        longint sa, sb;
        if (u) return {32'b0, a} * {32'b0, b};
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge while the DUT is idle; returns just after the accept edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic u);
        start = 1'b1;
        A     = a;
        B     = b;
        uop   = u;
        tick();
        start = 1'b0;
        chk("busy_on_accept", 64'(busy), 64'd1);
        chk("done_low_on_accept", 64'(done), 64'd0);
        chk("hilo_held_on_start", {Hi, Lo}, last_res);
    endtask

    // Waits (bounded) for done; 'elapsed' is cycles already spent since the accept edge.
    task automatic finish_op(input logic [63:0] exp, input int elapsed);
        int cyc = elapsed;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(N));
        chk("product", {Hi, Lo}, exp);
        chk("busy_off_at_done", 64'(busy), 64'd0);
        last_res = exp;
    endtask

    task automatic run_full(input logic [31:0] a, input logic [31:0] b, input logic u);
        logic [63:0] exp;
        exp = model(a, b, u);
        launch(a, b, u);
        finish_op(exp, 0);
        tick();
        chk("done_cleared", 64'(done), 64'd0);
        chk("hilo_hold_after_done", {Hi, Lo}, exp);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        logic ru;

        tick();
        tick();
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_hilo", {Hi, Lo}, 64'd0);

        run_full(32'd3, 32'd5, 1'b0);
        chk("spec_3x5", {Hi, Lo}, 64'h0000_0000_0000_000F);
        run_full(32'hFFFF_FFF9, 32'd6, 1'b0);
        chk("spec_m7x6", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFD6);
        run_full(32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("spec_minxmin", {Hi, Lo}, 64'h4000_0000_0000_0000);
        run_full(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("spec_m1xm1", {Hi, Lo}, 64'h0000_0000_0000_0001);
        run_full(32'd0, 32'h1234_5678, 1'b0);

        // start while busy is ignored; operands are not re-latched.
        launch(32'd2, 32'd2, 1'b0);
        repeat (9) tick();
        start = 1'b1;
        A     = 32'd9;
        B     = 32'd9;
        tick();
        start = 1'b0;
        chk("busy_ignores_start", 64'(busy), 64'd1);
        finish_op(64'd4, 10);
        // start in the done cycle is accepted immediately.
        launch(32'd3, 32'd7, 1'b0);
        finish_op(64'd21, 0);
        tick();
        chk("done_cleared_b2b", 64'(done), 64'd0);

        // Reset mid-operation aborts with no done pulse.
        launch(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hilo", {Hi, Lo}, 64'd0);
        last_res = '0;
        pulses = 0;
        repeat (40) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        run_full(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
        chk("spec_max_sq", {Hi, Lo}, 64'h3FFF_FFFF_0000_0001);

        // reset and start together: reset wins.
        reset = 1'b1;
        start = 1'b1;
        A     = 32'd5;
        B     = 32'd5;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("reset_beats_start", 64'(busy), 64'd0);
        tick();
        chk("reset_beats_start_2", 64'(busy), 64'd0);
        last_res = '0;

`ifdef MULT_MULTU_EN
        run_full(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("spec_multu_max", {Hi, Lo}, 64'hFFFF_FFFE_0000_0001);
        run_full(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_full(32'h8000_0000, 32'h8000_0000, 1'b1);
`endif

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            rb = $urandom;
`ifdef MULT_MULTU_EN
            ru = 1'($urandom_range(0, 1));
`else
            ru = 1'b0;
`endif
            run_full(ra, rb, ru);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
